// File: rtl/word_serializer_pkg.sv
// -----------------------------------------------------------------------------
// serializer_pkg
//   Shared types and helpers for the word serializer.
//   - ser_state_t : debug/waveform decode of the serializer's valid flag
//   - safe_clog2  : counter width helper, never returns less than one bit
// -----------------------------------------------------------------------------
package serializer_pkg;

    typedef enum logic {
        S_EMPTY    = 1'b0,
        S_SHIFTING = 1'b1
    } ser_state_t;

    // A ratio of 1 still needs a 1-bit counter so the vectors stay legal.
    function automatic int safe_clog2(input int n);
        int r;
        if (n <= 1) begin
            r = 1;
        end else begin
            r = $clog2(n);
        end
        return r;
    endfunction

endpackage

// File: rtl/word_serializer.sv
// -----------------------------------------------------------------------------
// word_serializer
//   Width-down converter: takes one in_width word per input handshake and
//   emits it as RATIO beats of out_width, least significant beat first, with
//   dOutLAST flagging the final beat. A new word can be accepted in the same
//   cycle the last beat leaves, so consecutive words stream without a bubble.
//
// Ports
//   clk       clock
//   rst       asynchronous active-high reset
//   dInREQ    out: ready to take a word
//   dInACK    in : upstream word valid
//   dIN       in : word data, only sampled on an input handshake
//   dOutACK   out: beat valid
//   dOutREQ   in : downstream ready for a beat
//   dOUT      out: current beat data
//   dOutLAST  out: current beat is the final beat of its word
// -----------------------------------------------------------------------------
module word_serializer
    import serializer_pkg::*;
#(
    parameter int in_width  = 32,
    parameter int out_width = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 dInREQ,
    input  logic                 dInACK,
    input  logic [in_width-1:0]  dIN,
    output logic                 dOutACK,
    input  logic                 dOutREQ,
    output logic [out_width-1:0] dOUT,
    output logic                 dOutLAST
);

    localparam int RATIO = in_width / out_width;
    localparam int CNT_W = safe_clog2(RATIO);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

    // The input word must split into a whole number of beats.
    if ((out_width < 1) || (in_width < out_width) || ((in_width % out_width) != 0)) begin : g_bad_width
        $error("word_serializer: in_width must be a positive multiple of out_width");
    end

    logic [in_width-1:0] sr_q;
    logic [in_width-1:0] sr_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                valid_q;
    logic                valid_d;

    ser_state_t          state_s;
    logic                last_s;
    logic                out_hs_s;
    logic                in_req_s;
    logic                in_hs_s;

    assign state_s  = valid_q ? S_SHIFTING : S_EMPTY;
    assign dOutACK  = (state_s == S_SHIFTING);
    assign dOUT     = sr_q[out_width-1:0];
    assign last_s   = dOutACK && (cnt_q == LAST_CNT);
    assign dOutLAST = last_s;
    assign out_hs_s = dOutACK && dOutREQ;
    // Ready when empty, or when the last beat of the current word leaves now.
    assign in_req_s = !dOutACK || (out_hs_s && last_s);
    assign dInREQ   = in_req_s;
    assign in_hs_s  = dInACK && in_req_s;

    // Next-state: load beats priority over shift; dIN only enters on a load.
    always_comb begin
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (in_hs_s) begin
            sr_d    = dIN;
            cnt_d   = {CNT_W{1'b0}};
            valid_d = 1'b1;
        end else if (out_hs_s && !last_s) begin
            // Zero-fill from the top so drained beats never resurface.
            sr_d    = sr_q >> out_width;
            cnt_d   = cnt_q + CNT_W'(1);
            valid_d = 1'b1;
        end else if (out_hs_s) begin
            // Last beat gone with no replacement word: go empty, sr left as is.
            cnt_d   = {CNT_W{1'b0}};
            valid_d = 1'b0;
        end else begin
            sr_d    = sr_q;
            cnt_d   = cnt_q;
            valid_d = valid_q;
        end
    end

    // State registers with asynchronous clear (discards any partial word).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q    <= {in_width{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            valid_q <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

endmodule
